// File: rtl/mem_load_pkg.sv
// Shared types and default sizing for the memory-load sequencer.
package mem_load_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        DONE     = 2'd2,
        WAIT_RDY = 2'd3
    } mls_state_e;

    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/mem_load_wdog.sv
// Watchdog for the ready handshake: counts enabled cycles and flags the
// TIMEOUT-th consecutive one. Cleared whenever the sequencer is not waiting.
module mem_load_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expire on the cycle whose count shows TIMEOUT-1 earlier waiting cycles.
    assign expire_o = en_i && (cnt_q == LAST);

    // Next count: clear dominates; hold once expired (the FSM leaves anyway).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_load_seq.sv
// Load sequencer: streams a counted burst from a valid/ready source into a
// memory write port, pulses done, then waits for the downstream ready.
//
// state    | meaning
// IDLE     | waiting for a start command
// LOAD     | accepting beats, load_mem high
// DONE     | one-cycle done pulse, last write visible
// WAIT_RDY | waiting for downstream ready, watchdog running
module mem_load_seq
    import mem_load_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] num_words,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          load_mem,
    output logic          done,
    input  logic          ready,
    output logic          busy,
    output logic          timeout_err
);

    mls_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          terr_q, terr_d;
    logic          wd_expire;

    mem_load_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != WAIT_RDY),
        .en_i     (state_q == WAIT_RDY),
        .expire_o (wd_expire)
    );

    // Next-state, datapath updates and watchdog handling.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    terr_d = 1'b0;
                    if (num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = base_addr;
                        cnt_d   = num_words;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = in_data;
                    addr_d  = addr_q + AW'(1);
                    cnt_d   = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            terr_q  <= terr_d;
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign load_mem    = (state_q == LOAD);
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign mem_we      = we_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = wdata_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_load_seq.sv
// Bench for mem_load_seq: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_mem_load_seq;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          load_mem;
    logic          done;
    logic          ready;
    logic          busy;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    mem_load_seq #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .load_mem    (load_mem),
        .done        (done),
        .ready       (ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 streaming, 2 done pulse, 3 waiting.
    int            m_phase;
    int            m_rem;
    int            m_wait;
    logic [AW-1:0] m_next;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic          m_terr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_rem = 0; m_wait = 0; m_next = '0;
            m_addr = '0; m_wdata = '0; m_we = 1'b0; m_terr = 1'b0;
        end else begin
            m_we = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_terr = 1'b0;
                    if (num_words == 0) m_phase = 2;
                    else begin
                        m_next = base_addr; m_rem = int'(num_words); m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    m_we = 1'b1; m_addr = m_next; m_wdata = in_data;
                    m_next = m_next + 8'd1;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_phase = 2;
                end
            end else if (m_phase == 2) begin
                m_phase = 3; m_wait = 0;
            end else begin
                if (ready) m_phase = 0;
                else begin
                    m_wait = m_wait + 1;
                    if (m_wait == TO) begin m_terr = 1'b1; m_phase = 0; end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("mem_we",      32'(mem_we),      32'(m_we));
        chk("mem_addr",    32'(mem_addr),    32'(m_addr));
        chk("mem_wdata",   32'(mem_wdata),   32'(m_wdata));
        chk("load_mem",    32'(load_mem),    32'(m_phase == 1));
        chk("in_ready",    32'(in_ready),    32'(m_phase == 1));
        chk("done",        32'(done),        32'(m_phase == 2));
        chk("busy",        32'(busy),        32'(m_phase != 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        in_valid = 1'b0; in_data = '0; ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we",   32'(mem_we), 32'd0);
        rst = 1'b0;
        step();

        // Basic burst
        base_addr = 8'h10; num_words = 8'd4; start = 1'b1; in_valid = 1'b1; in_data = 16'd1;
        step();
        start = 1'b0;
        chk("basic_load_c1", 32'(load_mem), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("basic_addr", 32'(mem_addr), 32'(8'h10 + i - 2));
            chk("basic_data", 32'(mem_wdata), 32'(i - 1));
            in_data = 16'(i);
        end
        step();
        in_valid = 1'b0;
        chk("basic_done_c5", 32'(done), 32'd1);
        chk("basic_we_c5",   32'(mem_we), 32'd1);
        chk("basic_addr_c5", 32'(mem_addr), 32'h13);
        chk("basic_data_c5", 32'(mem_wdata), 32'd4);
        chk("basic_load_c5", 32'(load_mem), 32'd0);
        step();
        chk("basic_busy_c6", 32'(busy), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("basic_busy_c7", 32'(busy), 32'd0);

        // Zero length
        num_words = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done_c1", 32'(done), 32'd1);
        chk("zero_we_c1",   32'(mem_we), 32'd0);
        chk("zero_load_c1", 32'(load_mem), 32'd0);
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("zero_idle", 32'(busy), 32'd0);

        // Wrap and stall
        base_addr = 8'hFE; num_words = 8'd3; start = 1'b1; in_valid = 1'b1; in_data = 16'hA1;
        step();
        start = 1'b0;
        step();
        chk("wrap_addr0", 32'(mem_addr), 32'hFE);
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1; in_data = 16'hA2;
        step();
        chk("wrap_addr1", 32'(mem_addr), 32'hFF);
        in_data = 16'hA3;
        step();
        chk("wrap_done_c6", 32'(done), 32'd1);
        chk("wrap_addr2",   32'(mem_addr), 32'h00);
        chk("wrap_data2",   32'(mem_wdata), 32'hA3);
        in_valid = 1'b0;
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Timeout
        base_addr = 8'h05; num_words = 8'd1; start = 1'b1; in_valid = 1'b1; in_data = 16'd7;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b0;
        chk("to_done_c2", 32'(done), 32'd1);
        repeat (4) step();
        chk("to_busy_c6", 32'(busy), 32'd1);
        chk("to_err_c6",  32'(timeout_err), 32'd0);
        step();
        chk("to_err_c7",  32'(timeout_err), 32'd1);
        chk("to_busy_c7", 32'(busy), 32'd0);
        num_words = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("to_err_clr", 32'(timeout_err), 32'd0);
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Ignored start during LOAD and ready with done
        base_addr = 8'h30; num_words = 8'd2; start = 1'b1; in_valid = 1'b1; in_data = 16'd9;
        step();
        num_words = 8'd0;
        step();
        start = 1'b0;
        step();
        chk("ign_done_c3", 32'(done), 32'd1);
        ready = 1'b1; in_valid = 1'b0;
        step();
        ready = 1'b0;
        chk("ign_busy_c4", 32'(busy), 32'd1);
        step();
        chk("ign_busy_c5", 32'(busy), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("ign_idle", 32'(busy), 32'd0);

        // Reset mid-burst
        base_addr = 8'h40; num_words = 8'd5; start = 1'b1; in_valid = 1'b1; in_data = 16'd100;
        step();
        start = 1'b0;
        step();
        in_data = 16'd101;
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_we",   32'(mem_we), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid_data", 32'(mem_wdata), 32'd0);
        chk("rst_mid_load", 32'(load_mem), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();
        base_addr = 8'h50; num_words = 8'd2; start = 1'b1; in_valid = 1'b1; in_data = 16'd55;
        step();
        start = 1'b0;
        step();
        step();
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'h51);
        in_valid = 1'b0; ready = 1'b1;
        step();
        step();
        ready = 1'b0;

        // Maximum burst
        base_addr = 8'h80; num_words = 8'd255; start = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        step();
        start = 1'b0;
        repeat (255) step();
        chk("max_done",   32'(done), 32'd1);
        chk("max_addr",   32'(mem_addr), 32'h7E);
        in_valid = 1'b0; ready = 1'b1;
        step();
        step();
        ready = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            start     = ($urandom_range(0, 3) == 0);
            base_addr = 8'($urandom);
            num_words = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            ready     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
